rv_sram_req_ctrl: RTL and testbench
===================================

RV_SRAM_REQ_CTRL -- requirements
Module: RV_sram_req_ctrl

Interface
REQ-001 The module SHALL have parameter DATAW, default 32, meaning data width in bits (must equal BYTEENW*8).
REQ-002 The module SHALL have parameter SIZE, default 64, meaning RAM depth in entries.
REQ-003 The module SHALL have parameter BYTEENW, default 4, meaning byte-enable width.
REQ-004 The module SHALL have parameter ADDRW, default $clog2(SIZE), meaning address width.
REQ-005 The module SHALL have parameter TAGW, default 4, meaning request tag width.
REQ-006 The module SHALL have parameter RSP_DEPTH, default 4, meaning response buffer entries (power of two, >=2).
REQ-007 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-008 The module SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-009 The module SHALL have ports req_valid (in, 1), req_rw (in, 1, 1=write), req_addr (in, ADDRW), req_byteen (in, BYTEENW), req_data (in, DATAW), req_tag (in, TAGW), req_ready (out, 1).
REQ-010 The module SHALL have ports rsp_valid (out, 1), rsp_data (out, DATAW), rsp_tag (out, TAGW), rsp_ready (in, 1).
REQ-011 The module SHALL have RAM-side ports ram_wren (out, BYTEENW), ram_addr (out, ADDRW), ram_wdata (out, DATAW), ram_rdata (in, DATAW), driving a single-port RAM with registered read (1-cycle read latency).

Function
REQ-012 Request fire SHALL be req_valid && req_ready sampled at a rising edge E0; only fired requests reach the RAM.
REQ-013 ram_addr SHALL equal req_addr and ram_wdata SHALL equal req_data combinationally.
REQ-014 ram_wren SHALL equal req_byteen when fire && req_rw, else all zeros.
REQ-015 A fired write SHALL produce no response and SHALL consume no credit.
REQ-016 A fired read SHALL set an in-flight flag at E0; at E0+1 ram_rdata and the held tag SHALL be pushed into the response buffer and the flag cleared, unless a new read fires at E0+1.
REQ-017 rsp_valid SHALL assert in the cycle after E0+1 (two edges after accept) when the buffer was previously empty.
REQ-018 Responses SHALL be returned strictly in request order.
REQ-019 rsp_valid SHALL be high whenever the buffer is non-empty; rsp_data and rsp_tag SHALL show the head entry and stay stable while rsp_valid && !rsp_ready.
REQ-020 The buffer SHALL pop on rsp_valid && rsp_ready; push and pop in the same cycle SHALL leave the count unchanged.
REQ-021 Read and write pointers SHALL be $clog2(RSP_DEPTH) bits and wrap from RSP_DEPTH-1 to 0.
REQ-022 req_ready SHALL be a function of registered state only: high iff (buffer count + in-flight flag) < RSP_DEPTH; it SHALL NOT depend combinationally on rsp_ready or any req_* input.
REQ-023 Buffer overflow SHALL be impossible by construction; a push into a full buffer is a design error flagged by an assertion.
REQ-024 With RSP_DEPTH>=3 and rsp_ready held high, back-to-back reads SHALL sustain one accept per cycle.
REQ-025 One RAM operation per cycle; read and write are never concurrent.

Reset
REQ-026 While reset is high: req_ready=0, rsp_valid=0, rsp_data=0, rsp_tag=0, ram_wren=0; buffer count, pointers and in-flight flag SHALL be cleared.
REQ-027 req_ready SHALL rise in the first cycle after reset is sampled low.
REQ-028 Reset asserted mid-operation SHALL discard in-flight reads and buffered responses; no response for them SHALL emerge after reset.

Verification
REQ-029 Write addr 5, byteen 4'b0101, data 0xAABBCCDD, then read addr 5, tag 3 (RAM pre-cleared) -> ram_wren=4'b0101 on write cycle only; response tag 3, data 0x00BB00DD two edges after read accept.
REQ-030 Eight back-to-back reads of addrs 0..7, tags 0..7, rsp_ready=1, RSP_DEPTH=4 -> req_ready never drops after first accept; tags 0..7 in order, one per cycle.
REQ-031 rsp_ready=0, issue reads until req_ready drops -> exactly 4 accepted; raise rsp_ready -> 4 in-order responses, req_ready returns high one cycle after first pop.
REQ-032 Hold rsp_ready=0 for 10 cycles with rsp_valid=1 -> rsp_data/rsp_tag unchanged throughout.
REQ-033 Assert reset one cycle after a read accept with 2 responses buffered -> rsp_valid=0 during and after reset, no stale response, req_ready=1 first cycle after reset release.
REQ-034 Write fired while req_ready=0 attempt (req_valid=1, buffer full) -> ram_wren stays 0, write occurs only once req_ready=1.

Source files
------------

// File: rtl/rv_sram_req_ctrl.sv
// Request front-end for a 1-cycle-read single-port SRAM; reads return data+tag in order via a small response FIFO.
// Read response appears two edges after accept; req_ready is credit-based on buffered + in-flight reads, never on rsp_ready.
module rv_sram_req_ctrl #(
  parameter int DATAW     = 32,
  parameter int SIZE      = 64,
  parameter int BYTEENW   = 4,
  parameter int ADDRW     = $clog2(SIZE),
  parameter int TAGW      = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               req_valid,
  input  logic               req_rw,
  input  logic [ADDRW-1:0]   req_addr,
  input  logic [BYTEENW-1:0] req_byteen,
  input  logic [DATAW-1:0]   req_data,
  input  logic [TAGW-1:0]    req_tag,
  output logic               req_ready,

  output logic               rsp_valid,
  output logic [DATAW-1:0]   rsp_data,
  output logic [TAGW-1:0]    rsp_tag,
  input  logic               rsp_ready,

  output logic [BYTEENW-1:0] ram_wren,
  output logic [ADDRW-1:0]   ram_addr,
  output logic [DATAW-1:0]   ram_wdata,
  input  logic [DATAW-1:0]   ram_rdata
);

  localparam int PTRW = $clog2(RSP_DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [DATAW-1:0] r_dat_mem [RSP_DEPTH];
  logic [TAGW-1:0]  r_tag_mem [RSP_DEPTH];
  logic [PTRW-1:0]  r_rd_ptr;
  logic [PTRW-1:0]  r_wr_ptr;
  logic [CNTW-1:0]  r_count;
  logic             r_inflight;
  logic [TAGW-1:0]  r_tag_hold;
  logic             r_rdy_en;

  logic [CNTW-1:0]  w_occ;
  logic             w_fire;
  logic             w_fire_rd;
  logic             w_push;
  logic             w_pop;

  // Credits count both buffered responses and the read whose data is still in the RAM pipeline.
  assign w_occ     = r_count + CNTW'(r_inflight);
  assign req_ready = !reset && r_rdy_en && (w_occ < CNTW'(RSP_DEPTH));

  assign w_fire    = req_valid && req_ready;
  assign w_fire_rd = w_fire && !req_rw;
  assign w_push    = r_inflight;
  assign w_pop     = rsp_valid && rsp_ready;

  assign ram_addr  = req_addr;
  assign ram_wdata = req_data;
  assign ram_wren  = (w_fire && req_rw) ? req_byteen : '0;

  assign rsp_valid = !reset && (r_count != '0);
  assign rsp_data  = rsp_valid ? r_dat_mem[r_rd_ptr] : '0;
  assign rsp_tag   = rsp_valid ? r_tag_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_tag_hold <= '0;
      r_rdy_en   <= 1'b0;
    end else begin
      r_rdy_en   <= 1'b1;
      r_inflight <= w_fire_rd;
      if (w_fire_rd) begin
        r_tag_hold <= req_tag;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTRW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTRW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push) begin
        assert (r_count < CNTW'(RSP_DEPTH));
      end
    end
  end

  // Payload storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_dat_mem[r_wr_ptr] <= ram_rdata;
      r_tag_mem[r_wr_ptr] <= r_tag_hold;
    end
  end

endmodule

// File: tb/tb_rv_sram_req_ctrl.sv
// Directed bench for rv_sram_req_ctrl with a behavioural 1-cycle-read byte-enable RAM.
module tb_rv_sram_req_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_rw;
  logic [5:0]  req_addr;
  logic [3:0]  req_byteen;
  logic [31:0] req_data;
  logic [3:0]  req_tag;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_ready;
  logic [3:0]  ram_wren;
  logic [5:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] ram [64] = '{default: '0};

  int n_chk = 0;
  int n_bad = 0;
  int acc;

  always #5 clk = ~clk;

  rv_sram_req_ctrl #(
    .DATAW(32), .SIZE(64), .BYTEENW(4), .ADDRW(6), .TAGW(4), .RSP_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_byteen(req_byteen), .req_data(req_data), .req_tag(req_tag),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready),
    .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_wren[b]) ram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
    ram_rdata <= ram[ram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic rw, input logic [5:0] a, input logic [3:0] be,
                     input logic [31:0] d, input logic [3:0] t);
    req_valid  = v;
    req_rw     = rw;
    req_addr   = a;
    req_byteen = be;
    req_data   = d;
    req_tag    = t;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    rsp_ready = 1'b0;
    drv(1'b1, 1'b1, 6'd0, 4'hF, 32'hFFFF_FFFF, 4'd0);
    tick();
    tick();
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    chk("rst_wren", 64'(ram_wren), 64'd0);

    drv(1'b0, 1'b0, 6'd0, 4'h0, 32'h0, 4'd0);
    reset = 1'b0;
    #1;
    chk("ready_before_release_edge", 64'(req_ready), 64'd0);
    tick();
    chk("ready_after_release", 64'(req_ready), 64'd1);

    // Partial-byte write then read-back of addr 5.
    drv(1'b1, 1'b1, 6'd5, 4'b0101, 32'hAABB_CCDD, 4'd0);
    #1;
    chk("wr_wren", 64'(ram_wren), 64'h5);
    chk("wr_addr", 64'(ram_addr), 64'd5);
    chk("wr_wdata", 64'(ram_wdata), 64'hAABB_CCDD);
    tick();
    drv(1'b1, 1'b0, 6'd5, 4'hF, 32'h0, 4'd3);
    #1;
    chk("rd_wren_zero", 64'(ram_wren), 64'd0);
    tick();
    drv(1'b0, 1'b0, 6'd0, 4'h0, 32'h0, 4'd0);
    #1;
    chk("rd_no_rsp_at_e0", 64'(rsp_valid), 64'd0);
    tick();
    #1;
    chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rd_rsp_tag", 64'(rsp_tag), 64'd3);
    chk("rd_rsp_data", 64'(rsp_data), 64'h00BB_00DD);
    rsp_ready = 1'b1;
    tick();
    #1;
    chk("rd_popped", 64'(rsp_valid), 64'd0);

    // Back-to-back reads, one accept and one response per cycle.
    for (int c = 0; c < 11; c++) begin
      if (c < 8) drv(1'b1, 1'b0, 6'(c), 4'hF, 32'h0, 4'(c));
      else       drv(1'b0, 1'b0, 6'd0, 4'h0, 32'h0, 4'd0);
      #1;
      if (c < 8) chk("b2b_ready", 64'(req_ready), 64'd1);
      if (c >= 2 && c < 10) begin
        chk("b2b_valid", 64'(rsp_valid), 64'd1);
        chk("b2b_tag", 64'(rsp_tag), 64'(c - 2));
        chk("b2b_data", 64'(rsp_data), (c - 2 == 5) ? 64'h00BB_00DD : 64'd0);
      end
      if (c == 10) chk("b2b_drained", 64'(rsp_valid), 64'd0);
      tick();
    end

    // Fill the response buffer with rsp_ready low.
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 1'b0, (i == 0) ? 6'd5 : 6'(i), 4'hF, 32'h0, 4'(8 + i));
      #1;
      if (!req_ready) break;
      acc++;
      tick();
    end
    chk("fill_accepts", 64'(acc), 64'd4);

    // Write attempt while full must not reach the RAM.
    drv(1'b1, 1'b1, 6'd9, 4'hF, 32'h1234_5678, 4'd0);
    #1;
    chk("full_wr_blocked", 64'(ram_wren), 64'd0);
    tick();
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_tag", 64'(rsp_tag), 64'd8);
      chk("hold_data", 64'(rsp_data), 64'h00BB_00DD);
      chk("hold_wren", 64'(ram_wren), 64'd0);
      chk("hold_ready", 64'(req_ready), 64'd0);
      tick();
    end

    rsp_ready = 1'b1;
    #1;
    chk("ready_before_pop", 64'(req_ready), 64'd0);
    chk("wren_before_pop", 64'(ram_wren), 64'd0);
    tick();
    #1;
    chk("ready_after_pop", 64'(req_ready), 64'd1);
    chk("wren_after_pop", 64'(ram_wren), 64'hF);
    chk("drain_tag9", 64'(rsp_tag), 64'd9);
    tick();
    drv(1'b0, 1'b0, 6'd0, 4'h0, 32'h0, 4'd0);
    #1;
    chk("drain_tag10", 64'(rsp_tag), 64'd10);
    tick();
    #1;
    chk("drain_tag11", 64'(rsp_tag), 64'd11);
    tick();
    #1;
    chk("drain_empty", 64'(rsp_valid), 64'd0);

    // The blocked write must have landed exactly once.
    drv(1'b1, 1'b0, 6'd9, 4'hF, 32'h0, 4'd7);
    tick();
    drv(1'b0, 1'b0, 6'd0, 4'h0, 32'h0, 4'd0);
    tick();
    #1;
    chk("wb_valid", 64'(rsp_valid), 64'd1);
    chk("wb_tag", 64'(rsp_tag), 64'd7);
    chk("wb_data", 64'(rsp_data), 64'h1234_5678);
    tick();
    #1;
    chk("wb_popped", 64'(rsp_valid), 64'd0);

    // Reset with two responses buffered and one read in flight.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b0, 6'(i), 4'hF, 32'h0, 4'(i + 1));
      tick();
    end
    drv(1'b0, 1'b0, 6'd0, 4'h0, 32'h0, 4'd0);
    #1;
    chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
    chk("pre_rst_tag", 64'(rsp_tag), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_data", 64'(rsp_data), 64'd0);
    tick();
    #1;
    chk("in_rst_valid", 64'(rsp_valid), 64'd0);
    chk("in_rst_ready", 64'(req_ready), 64'd0);
    tick();
    reset     = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("rel_ready_low", 64'(req_ready), 64'd0);
    tick();
    chk("rel_ready_high", 64'(req_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("no_stale_rsp", 64'(rsp_valid), 64'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
